dm_responder: RTL
=================

Name: dm_responder

Overview:
Memory-side responder for the datapath's load/store traffic. It accepts one request at a time over a valid/ready channel, performs the load or store against an internal byte-wide data memory after a programmable number of wait states, and returns a response over a second valid/ready channel. It sits between the core's load/store issue logic and data storage, replacing the direct combinational dat_mem hookup with a handshaked, multi-cycle interface.

Parameters:
AW, 8, address width in bits
DW, 8, data width in bits
DEPTH, 256, number of implemented words; legal addresses are 0..DEPTH-1, and DEPTH must be at most 2**AW
LAT, 2, wait cycles between request acceptance and memory access; range 0..15

Ports:
clk  in  1  clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  AW  word address
req_wdata  in  DW  store data
resp_valid  out  1  response present
resp_ready  in  1  initiator accepts the response
resp_we  out  1  echo of the accepted req_we
resp_rdata  out  DW  load data; 0 for stores
resp_err  out  1  address was >= DEPTH
load_cnt  out  16  completed loads, saturating
store_cnt  out  16  completed stores, saturating
busy  out  1  state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE and any in-flight transaction is dropped. req_ready=1; resp_valid, resp_we, resp_err, busy=0; resp_rdata=0; load_cnt and store_cnt=0. Memory contents are not reset and are retained across reset.
- State IDLE: req_ready=1. When req_valid=1 on a rising edge, the request is accepted and req_we, req_addr and req_wdata are captured.
  - If LAT>0, the next state is WAIT and the wait counter is loaded with LAT-1.
  - If LAT=0, the memory access happens on the acceptance edge and the next state is RESP.
- State WAIT: req_ready=0. The wait counter decrements each cycle. When it reaches 0, the access happens on that edge and the next state is RESP.
- Response timing: resp_valid rises immediately after edge E0+LAT, where E0 is the acceptance edge.
- Memory access:
  - Store with addr < DEPTH: mem[addr] <= wdata; resp_rdata=0.
  - Load with addr < DEPTH: resp_rdata <= mem[addr].
  - addr >= DEPTH: no write; resp_rdata = all ones; resp_err=1.
- State RESP: resp_valid=1, req_ready=0. Response fields are held stable until resp_valid && resp_ready are both 1 on an edge.
  - On that handshake edge: the next state is IDLE and resp_valid drops.
  - Also on that edge: load_cnt or store_cnt increments (per resp_we), saturating at 16'hFFFF. Errored transactions are counted too.
- Throughput: a new request is accepted at the earliest on the edge after the response handshake. Minimum period is LAT+2 cycles. There is no overlap and no acceptance in RESP.
- While req_ready=0, req_* inputs are ignored.
- busy = (state != IDLE).
- Store followed by a load to the same address returns the stored value; no bypass is needed because accesses are serialized.
- resp_ready held at 1 before a response is valid has no effect.

Decomposition:
- Shared package dm_pkg: state enum (IDLE, WAIT, RESP), default AW/DW/DEPTH/LAT constants, and the 16-bit counter width constant.
- One sub-module dm_array: synchronous-write, registered-read DEPTH x DW storage, with write-enable, read-enable, address, wdata and rdata ports. The FSM, counters and handshakes stay in dm_responder.

Test Plan:
- Reset, then idle: req_ready=1, resp_valid=0, counters=0, busy=0.
- LAT=2: store addr 10 data 32, resp_ready=1 → resp_valid high 2 cycles after acceptance with resp_we=1, rdata=0, err=0; store_cnt=1.
- Store addr 4 data 46, then load addr 10, then load addr 4 → rdata 32, then 46; load_cnt=2, store_cnt=2; req_ready low from acceptance through the response handshake.
- Backpressure: load with resp_ready=0 for 5 cycles → resp_valid and rdata held stable; no new request accepted; handshake on cycle 6 returns to IDLE.
- DEPTH=200, LAT=0: load addr 250 → response on the next cycle with err=1, rdata=8'hFF; store addr 250 leaves memory unchanged (a later load of a legal address is unaffected).
- Assert reset in WAIT → outputs return to reset values immediately, and no response is issued. After release, loading addr 10 returns 32 (memory retained).

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and defaults for the handshaked data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int DM_AW    = 8;
  localparam int DM_DW    = 8;
  localparam int DM_DEPTH = 256;
  localparam int DM_LAT   = 2;
  localparam int DM_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DM_CNT_W-1:0] sat_inc(input logic [DM_CNT_W-1:0] v);
    return (&v) ? v : v + DM_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dm_array.sv
// DEPTH x DW data storage: synchronous write, registered read, no reset so it maps to block RAM.
module dm_array
  import dm_pkg::*;
#(
  parameter int AW    = DM_AW,
  parameter int DW    = DM_DW,
  parameter int DEPTH = DM_DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Load/store responder: accepts one request, waits LAT cycles, accesses dm_array, then
// holds the response until the initiator takes it.
module dm_responder
  import dm_pkg::*;
#(
  parameter int AW    = DM_AW,
  parameter int DW    = DM_DW,
  parameter int DEPTH = DM_DEPTH,
  parameter int LAT   = DM_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [AW-1:0]       req_addr,
  input  logic [DW-1:0]       req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_we,
  output logic [DW-1:0]       resp_rdata,
  output logic                resp_err,
  output logic [DM_CNT_W-1:0] load_cnt,
  output logic [DM_CNT_W-1:0] store_cnt,
  output logic                busy
);

  localparam int WCW = 4;

  dm_state_e state_reg, state_next;
  logic [WCW-1:0] wait_reg, wait_next;

  logic          cap_we_reg;
  logic [AW-1:0] cap_addr_reg;
  logic [DW-1:0] cap_wdata_reg;

  logic                resp_we_reg, resp_err_reg;
  logic [DM_CNT_W-1:0] load_cnt_reg, store_cnt_reg;

  logic          accept, acc_fire, acc_we, acc_ok, handshake;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata, arr_rdata;

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    accept     = 1'b0;
    acc_fire   = 1'b0;
    handshake  = 1'b0;
    acc_we     = cap_we_reg;
    acc_addr   = cap_addr_reg;
    acc_wdata  = cap_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          // With no wait states the access uses the live request on the acceptance edge.
          if (LAT == 0) begin
            acc_fire   = 1'b1;
            acc_we     = req_we;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            state_next = RESP;
          end else begin
            wait_next  = WCW'(LAT > 0 ? LAT - 1 : 0);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_reg == '0) begin
          acc_fire   = 1'b1;
          state_next = RESP;
        end else begin
          wait_next = wait_reg - WCW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign acc_ok = (32'(acc_addr) < 32'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      wait_reg      <= '0;
      resp_we_reg   <= 1'b0;
      resp_err_reg  <= 1'b0;
      load_cnt_reg  <= '0;
      store_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (acc_fire) begin
        resp_we_reg  <= acc_we;
        resp_err_reg <= ~acc_ok;
      end
      if (handshake) begin
        if (resp_we_reg) begin
          store_cnt_reg <= sat_inc(store_cnt_reg);
        end else begin
          load_cnt_reg <= sat_inc(load_cnt_reg);
        end
      end
    end
  end

  // Request capture is pure datapath; it is only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we_reg    <= req_we;
      cap_addr_reg  <= req_addr;
      cap_wdata_reg <= req_wdata;
    end
  end

  dm_array #(
    .AW   (AW),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (acc_fire && acc_we && acc_ok),
    .re   (acc_fire && !acc_we && acc_ok),
    .addr (acc_addr),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // The array read register is never reset, so rdata is masked outside RESP.
  always_comb begin
    resp_rdata = '0;
    if (state_reg == RESP) begin
      if (resp_err_reg) begin
        resp_rdata = '1;
      end else if (!resp_we_reg) begin
        resp_rdata = arr_rdata;
      end
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);
  assign resp_we    = resp_we_reg;
  assign resp_err   = resp_err_reg;
  assign load_cnt   = load_cnt_reg;
  assign store_cnt  = store_cnt_reg;

endmodule
